pll_reconfig_master: RTL and testbench
======================================

# pll_reconfig_master

Avalon-MM initiator that drives the management port of the Cyclone V PLL reconfiguration controller sitting between the core and the reconfigurable system PLL (`reconfig_to_pll`/`reconfig_from_pll`). On a single request it writes new M, fractional K, one C counter, bandwidth and charge-pump settings, then triggers reconfiguration. It reports completion once the PLL has re-locked and stayed locked, or a timeout. Used to switch the core clock between presets (e.g. 85 MHz and alternates) at run time.

## Interface
- `LOCK_TIMEOUT`, default 1000000: cycles allowed from request acceptance to `done` (20 ms at 50 MHz).
- `LOCK_STABLE`, default 16: consecutive `pll_locked`=1 samples required for completion; at least 1.
- `C_INDEX`, default 0: C counter index written, 0..17.
- `BW_SETTING`, default 4'd6: bandwidth register value.
- `CP_SETTING`, default 3'd1: charge-pump register value.

Ports:
- `refclk` in 1: management clock, 50 MHz.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request strobe.
- `req_ready` out 1: request can be accepted.
- `req_m_hi` in 8, `req_m_lo` in 8, `req_m_odd` in 1: M counter high/low counts and odd-duty flag.
- `req_k` in 32: fractional K.
- `req_c_hi` in 8, `req_c_lo` in 8, `req_c_odd` in 1: C counter fields.
- `mgmt_address` out 6, `mgmt_write` out 1, `mgmt_writedata` out 32, `mgmt_waitrequest` in 1: Avalon-MM write master.
- `pll_locked` in 1: PLL lock, already synchronous to `refclk`.
- `busy` out 1: equals `!req_ready`.
- `done` out 1: one-cycle pulse on success.
- `timeout` out 1: one-cycle pulse on failure.

## Operation
- FSM states: IDLE, WR_MODE, WR_M, WR_K, WR_C, WR_BW, WR_CP, WR_START, WAIT_LOCK.
- `req_ready` = (state==IDLE).
- A request is accepted when `req_valid & req_ready`. On acceptance:
  - all `req_*` fields are registered;
  - the timeout counter is cleared;
  - next state is WR_MODE.
- Write sequence, as (address, data):
  - WR_MODE: (0x00, 0) — waitrequest mode.
  - WR_M: (0x04, {14'b0, m_odd, 1'b0, m_hi, m_lo}).
  - WR_K: (0x07, k).
  - WR_C: (0x05, {9'b0, C_INDEX[4:0], c_odd, 1'b0, c_hi, c_lo}).
  - WR_BW: (0x08, {28'b0, BW_SETTING}).
  - WR_CP: (0x09, {29'b0, CP_SETTING}).
  - WR_START: (0x02, 1).
- In each WR_* state, `mgmt_write`=1 and address/data stay constant.
  - A write completes on a cycle with `mgmt_waitrequest`=0; the FSM then advances.
  - The START write is held by the slave for the whole reconfiguration.
- WAIT_LOCK: the stable counter increments on each `pll_locked`=1 cycle and clears to 0 on any `pll_locked`=0 cycle. When the counter reaches LOCK_STABLE, the FSM goes to IDLE with `done` pulsed.
- The timeout counter runs in every non-IDLE state. When it reaches LOCK_TIMEOUT, the FSM goes to IDLE with `timeout` pulsed and `mgmt_write` dropped. This abandons a write, including one stalled by `waitrequest`.
- If `done` and timeout fire on the same cycle, `done` wins and `timeout` stays 0.
- `req_*` changes while busy are ignored.

## Timing
- Reset values: state IDLE, `req_ready`=1, `busy`=0, `mgmt_write`=0, `mgmt_address`=0, `mgmt_writedata`=0, `done`=0, `timeout`=0, both counters 0.
- Assertion of `rst_n`=0 mid-sequence:
  - `mgmt_write` falls immediately (asynchronously) and no further writes are issued;
  - after release the block is in IDLE.
- All outputs are registered except `req_ready`/`busy`, which decode the state register.
- Accept at cycle 0 → WR_MODE write visible at cycle 1.
- With `waitrequest` always 0, the seven writes occupy cycles 1..7; WAIT_LOCK is entered at cycle 8.
- With `pll_locked` held 1, `done` is high at cycle 8+LOCK_STABLE, together with `req_ready`=1. A new request may be accepted in that same cycle.
- Counter widths: `$clog2(LOCK_TIMEOUT+1)` and `$clog2(LOCK_STABLE+1)`; both saturate and never wrap.

## Structure
- Shared package `pll_reconfig_pkg`:
  - register address constants (MODE, STATUS, START, N, M, C, K, BW, CP);
  - counter-word field offsets (odd bit 17, bypass bit 16, C select [22:18]);
  - FSM state enum.
- Sub-module `pll_lock_qualifier`:
  - inputs `refclk`, `rst_n`, `clear`, `pll_locked`;
  - output `stable`, with the LOCK_STABLE consecutive-sample rule.

## Test plan
- Request m_hi=4, m_lo=4, m_odd=0, k=0x80000000, c_hi=3, c_lo=2, c_odd=1, C_INDEX=0, `waitrequest`=0:
  - writes in order (0x00,0), (0x04,0x00000404), (0x07,0x80000000), (0x05,0x00020302), (0x08,6), (0x09,1), (0x02,1);
  - with `pll_locked` held 1, `done` at cycle 24 (8+16).
- `waitrequest` held 1 for 5 cycles on the M write → address 0x04 and its data stay stable for all 5 stalled cycles; the following write is K (0x07).
- In WAIT_LOCK, `pll_locked` runs 1 for 10 cycles, 0 for 1, then 1 → `done` arrives 16 cycles after the final rise, not earlier.
- LOCK_TIMEOUT=100 with `pll_locked` stuck 0 → `timeout` pulses exactly 100 cycles after acceptance; `done` never asserts; `req_ready`=1 afterwards.
- `rst_n` pulsed low during WR_K → `mgmt_write`=0 immediately and all outputs return to reset values. A fresh request afterwards restarts the sequence at address 0x00.

Source files
------------

// File: rtl/pll_reconfig_pkg.sv
// Shared definitions for the PLL reconfiguration master: register map, counter-word
// layout and the sequencer state encoding.
package pll_reconfig_pkg;

  localparam logic [5:0] ADDR_MODE   = 6'h00;
  localparam logic [5:0] ADDR_STATUS = 6'h01;
  localparam logic [5:0] ADDR_START  = 6'h02;
  localparam logic [5:0] ADDR_N      = 6'h03;
  localparam logic [5:0] ADDR_M      = 6'h04;
  localparam logic [5:0] ADDR_C      = 6'h05;
  localparam logic [5:0] ADDR_K      = 6'h07;
  localparam logic [5:0] ADDR_BW     = 6'h08;
  localparam logic [5:0] ADDR_CP     = 6'h09;

  localparam int CNT_ODD_BIT    = 17;
  localparam int CNT_BYPASS_BIT = 16;
  localparam int CNT_CSEL_LSB   = 18;
  localparam int CNT_CSEL_MSB   = 22;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_MODE,
    ST_WR_M,
    ST_WR_K,
    ST_WR_C,
    ST_WR_BW,
    ST_WR_CP,
    ST_WR_START,
    ST_WAIT_LOCK
  } state_t;

  // Builds an M/C counter word; the bypass bit is always left clear.
  function automatic logic [31:0] counter_word(input logic [7:0] hi, input logic [7:0] lo,
                                               input logic odd, input logic [4:0] csel);
    logic [31:0] w;
    w = '0;
    w[7:0]                        = lo;
    w[15:8]                       = hi;
    w[CNT_BYPASS_BIT]             = 1'b0;
    w[CNT_ODD_BIT]                = odd;
    w[CNT_CSEL_MSB:CNT_CSEL_LSB]  = csel;
    return w;
  endfunction

endpackage

// File: rtl/pll_reconfig_master_lock_qualifier.sv
// Declares the PLL locked once LOCK_STABLE consecutive pll_locked samples have been seen.
// 'stable' rises on the sample that completes the run, so a registered consumer acts on it next edge.
module pll_lock_qualifier #(
  parameter int unsigned LOCK_STABLE = 16
) (
  input  logic refclk,
  input  logic rst_n,
  input  logic clear,
  input  logic pll_locked,
  output logic stable
);

  localparam int W = $clog2(LOCK_STABLE + 1);
  localparam logic [W-1:0] CNT_MAX  = W'(LOCK_STABLE);
  localparam logic [W-1:0] CNT_LAST = W'(LOCK_STABLE - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear || !pll_locked) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign stable = !clear && pll_locked && (r_cnt >= CNT_LAST);

endmodule

// File: rtl/pll_reconfig_master.sv
// Avalon-MM write master that programs M, K, one C counter, bandwidth and charge pump
// into the PLL reconfiguration controller, starts it, and waits for a stable re-lock.
module pll_reconfig_master
  import pll_reconfig_pkg::*;
#(
  parameter int unsigned LOCK_TIMEOUT = 1000000,
  parameter int unsigned LOCK_STABLE  = 16,
  parameter int unsigned C_INDEX      = 0,
  parameter logic [3:0]  BW_SETTING   = 4'd6,
  parameter logic [2:0]  CP_SETTING   = 3'd1
) (
  input  logic        refclk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_m_hi,
  input  logic [7:0]  req_m_lo,
  input  logic        req_m_odd,
  input  logic [31:0] req_k,
  input  logic [7:0]  req_c_hi,
  input  logic [7:0]  req_c_lo,
  input  logic        req_c_odd,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic [31:0] mgmt_writedata,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output state_t      dbg_state
);

  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(LOCK_TIMEOUT);
  // Counter holds (cycles since acceptance - 1); firing here lands the registered pulse
  // exactly LOCK_TIMEOUT cycles after acceptance.
  localparam logic [TW-1:0] TO_FIRE = TW'((LOCK_TIMEOUT >= 2) ? (LOCK_TIMEOUT - 2) : 0);
  localparam logic [4:0]    C_SEL   = 5'(C_INDEX);

  state_t        r_state;
  logic          r_write;
  logic [5:0]    r_addr;
  logic [31:0]   r_data;
  logic          r_done;
  logic          r_timeout;
  logic [7:0]    r_m_hi, r_m_lo, r_c_hi, r_c_lo;
  logic          r_m_odd, r_c_odd;
  logic [31:0]   r_k;
  logic [TW-1:0] r_to_cnt;
  logic          w_stable;
  logic          w_to_fire;
  logic          w_accept;

  // Request handshake: a request transfers on any edge where req_valid and req_ready are
  // both high; req_ready is high only in IDLE and the payload is captured on that edge.
  assign req_ready = (r_state == ST_IDLE);
  assign busy      = !req_ready;
  assign w_accept  = req_valid && req_ready;
  assign w_to_fire = (r_to_cnt >= TO_FIRE);

  assign mgmt_write     = r_write;
  assign mgmt_address   = r_addr;
  assign mgmt_writedata = r_data;
  assign done           = r_done;
  assign timeout        = r_timeout;
  assign dbg_state      = r_state;

  pll_lock_qualifier #(.LOCK_STABLE(LOCK_STABLE)) u_lock_qual (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .clear      (r_state != ST_WAIT_LOCK),
    .pll_locked (pll_locked),
    .stable     (w_stable)
  );

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if (w_accept) begin
      r_to_cnt <= '0;
    end else if (r_state != ST_IDLE && r_to_cnt != TO_MAX) begin
      r_to_cnt <= r_to_cnt + TW'(1);
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_write   <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_m_hi    <= '0;
      r_m_lo    <= '0;
      r_m_odd   <= 1'b0;
      r_k       <= '0;
      r_c_hi    <= '0;
      r_c_lo    <= '0;
      r_c_odd   <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (req_valid) begin
          r_m_hi  <= req_m_hi;
          r_m_lo  <= req_m_lo;
          r_m_odd <= req_m_odd;
          r_k     <= req_k;
          r_c_hi  <= req_c_hi;
          r_c_lo  <= req_c_lo;
          r_c_odd <= req_c_odd;
          r_state <= ST_WR_MODE;
          r_write <= 1'b1;
          r_addr  <= ADDR_MODE;
          r_data  <= '0;
        end
      end else if (r_state == ST_WAIT_LOCK && w_stable) begin
        r_done  <= 1'b1;
        r_state <= ST_IDLE;
      end else if (w_to_fire) begin
        // Abandons whatever write is on the bus, even one stalled by waitrequest.
        r_timeout <= 1'b1;
        r_write   <= 1'b0;
        r_state   <= ST_IDLE;
      end else if (!mgmt_waitrequest) begin
        case (r_state)
          ST_WR_MODE: begin
            r_state <= ST_WR_M;
            r_addr  <= ADDR_M;
            r_data  <= counter_word(r_m_hi, r_m_lo, r_m_odd, 5'd0);
          end
          ST_WR_M: begin
            r_state <= ST_WR_K;
            r_addr  <= ADDR_K;
            r_data  <= r_k;
          end
          ST_WR_K: begin
            r_state <= ST_WR_C;
            r_addr  <= ADDR_C;
            r_data  <= counter_word(r_c_hi, r_c_lo, r_c_odd, C_SEL);
          end
          ST_WR_C: begin
            r_state <= ST_WR_BW;
            r_addr  <= ADDR_BW;
            r_data  <= {28'b0, BW_SETTING};
          end
          ST_WR_BW: begin
            r_state <= ST_WR_CP;
            r_addr  <= ADDR_CP;
            r_data  <= {29'b0, CP_SETTING};
          end
          ST_WR_CP: begin
            r_state <= ST_WR_START;
            r_addr  <= ADDR_START;
            r_data  <= 32'd1;
          end
          ST_WR_START: begin
            r_state <= ST_WAIT_LOCK;
            r_write <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_reconfig_master.sv
// Randomized bench for pll_reconfig_master: per-cycle waitrequest/lock stimulus is
// precomputed, and a cycle-level model predicts the writes and the done/timeout cycle.
module tb_pll_reconfig_master;
  import pll_reconfig_pkg::*;

  localparam int TO     = 100;
  localparam int STABLE = 16;
  localparam int CIDX   = 0;
  localparam int BW     = 6;
  localparam int CP     = 1;
  localparam int WIN    = 110;

  logic        refclk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_m_hi, req_m_lo, req_c_hi, req_c_lo;
  logic        req_m_odd, req_c_odd;
  logic [31:0] req_k;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic [31:0] mgmt_writedata;
  logic        mgmt_waitrequest;
  logic        pll_locked;
  logic        busy, done, timeout;
  state_t      dbg_state;

  pll_reconfig_master #(.LOCK_TIMEOUT(TO), .LOCK_STABLE(STABLE), .C_INDEX(CIDX)) dut (
    .refclk(refclk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_m_hi(req_m_hi), .req_m_lo(req_m_lo), .req_m_odd(req_m_odd), .req_k(req_k),
    .req_c_hi(req_c_hi), .req_c_lo(req_c_lo), .req_c_odd(req_c_odd),
    .mgmt_address(mgmt_address), .mgmt_write(mgmt_write), .mgmt_writedata(mgmt_writedata),
    .mgmt_waitrequest(mgmt_waitrequest), .pll_locked(pll_locked), .busy(busy),
    .done(done), .timeout(timeout), .dbg_state(dbg_state)
  );

  // clock / reset
  initial refclk = 1'b0;
  always #10 refclk = ~refclk;

  int cyc = 0;
  always @(posedge refclk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // stimulus tables and request fields, indexed by cycle offset from acceptance
  logic        wreq_arr[WIN];
  logic        lock_arr[WIN];
  logic [7:0]  t_m_hi, t_m_lo, t_c_hi, t_c_lo;
  logic        t_m_odd, t_c_odd;
  logic [31:0] t_k;

  // scoreboard
  logic [37:0] exp_q[$];
  int          exp_cyc_q[$];
  int          exp_done, exp_to;
  int          got_done, got_to, n_done, n_to;
  int          base;
  bit          mon_on = 0;
  bit          prev_stall;
  logic [5:0]  prev_addr;
  logic [31:0] prev_data;

  task automatic build_model();
    logic [37:0] w[7];
    int unsigned m_word, c_word;
    int c, nw, run;
    m_word = int'(t_m_odd) * 131072 + int'(t_m_hi) * 256 + int'(t_m_lo);
    c_word = CIDX * 262144 + int'(t_c_odd) * 131072 + int'(t_c_hi) * 256 + int'(t_c_lo);
    w[0] = {6'h00, 32'd0};
    w[1] = {6'h04, m_word};
    w[2] = {6'h07, t_k};
    w[3] = {6'h05, c_word};
    w[4] = {6'h08, 32'(BW)};
    w[5] = {6'h09, 32'(CP)};
    w[6] = {6'h02, 32'd1};
    exp_q.delete();
    exp_cyc_q.delete();
    exp_done = -1;
    exp_to   = -1;
    c  = 1;
    nw = 0;
    while (nw < 7) begin
      while (c < TO && wreq_arr[c]) c++;
      if (c >= TO) break;
      exp_q.push_back(w[nw]);
      exp_cyc_q.push_back(c);
      nw++;
      c++;
    end
    if (nw == 7) begin
      run = 0;
      for (int t = c; t < TO; t++) begin
        run = lock_arr[t] ? run + 1 : 0;
        if (run == STABLE) begin
          exp_done = t + 1;
          break;
        end
      end
    end
    if (exp_done < 0) exp_to = TO;
  endtask

  always @(negedge refclk) begin
    int off;
    if (mon_on) begin
      off = cyc - base;
      if (off == 0) check_eq("accept_ready", {63'b0, req_ready}, 64'd1);
      if (prev_stall)
        check_eq("stall_hold", {25'b0, mgmt_write, mgmt_address, mgmt_writedata},
                 {25'b0, 1'b1, prev_addr, prev_data});
      if (mgmt_write && !mgmt_waitrequest) begin
        check_eq("write_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          check_eq("write_word", {26'b0, mgmt_address, mgmt_writedata}, {26'b0, exp_q.pop_front()});
          check_eq("write_cycle", 64'(off), 64'(exp_cyc_q.pop_front()));
        end
      end
      prev_stall = mgmt_write && mgmt_waitrequest;
      prev_addr  = mgmt_address;
      prev_data  = mgmt_writedata;
      if (done) begin
        n_done++;
        if (got_done < 0) got_done = off;
      end
      if (timeout) begin
        n_to++;
        if (got_to < 0) got_to = off;
      end
    end
  end

  // driver
  task automatic run_txn();
    build_model();
    @(posedge refclk); #1;
    base       = cyc;
    got_done   = -1;
    got_to     = -1;
    n_done     = 0;
    n_to       = 0;
    prev_stall = 0;
    req_m_hi = t_m_hi; req_m_lo = t_m_lo; req_m_odd = t_m_odd; req_k = t_k;
    req_c_hi = t_c_hi; req_c_lo = t_c_lo; req_c_odd = t_c_odd;
    req_valid        = 1'b1;
    mgmt_waitrequest = wreq_arr[0];
    pll_locked       = lock_arr[0];
    mon_on           = 1;
    for (int off = 1; off < WIN; off++) begin
      @(posedge refclk); #1;
      req_valid = 1'b0;
      req_m_hi  = 8'($urandom); req_m_lo = 8'($urandom); req_m_odd = 1'($urandom);
      req_k     = $urandom;
      req_c_hi  = 8'($urandom); req_c_lo = 8'($urandom); req_c_odd = 1'($urandom);
      mgmt_waitrequest = wreq_arr[off];
      pll_locked       = lock_arr[off];
    end
    @(posedge refclk); #1;
    mon_on = 0;
    check_eq("writes_left", 64'(exp_q.size()), 64'd0);
    check_eq("done_cycle", 64'(got_done), 64'(exp_done));
    check_eq("timeout_cycle", 64'(got_to), 64'(exp_to));
    check_eq("done_pulses", 64'(n_done), 64'(exp_done >= 0 ? 1 : 0));
    check_eq("timeout_pulses", 64'(n_to), 64'(exp_to >= 0 ? 1 : 0));
    check_eq("ready_after", {63'b0, req_ready}, 64'd1);
    check_eq("write_after", {63'b0, mgmt_write}, 64'd0);
  endtask

  task automatic set_plan_req();
    t_m_hi = 8'd4; t_m_lo = 8'd4; t_m_odd = 1'b0; t_k = 32'h8000_0000;
    t_c_hi = 8'd3; t_c_lo = 8'd2; t_c_odd = 1'b1;
  endtask

  task automatic fill(input bit wr_val, input bit lk_val);
    for (int i = 0; i < WIN; i++) begin
      wreq_arr[i] = wr_val;
      lock_arr[i] = lk_val;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, {63'b0, req_ready}, 64'd1);
    check_eq({tag, "_busy"}, {63'b0, busy}, 64'd0);
    check_eq({tag, "_write"}, {63'b0, mgmt_write}, 64'd0);
    check_eq({tag, "_addr"}, {58'b0, mgmt_address}, 64'd0);
    check_eq({tag, "_data"}, {32'b0, mgmt_writedata}, 64'd0);
    check_eq({tag, "_done"}, {63'b0, done}, 64'd0);
    check_eq({tag, "_timeout"}, {63'b0, timeout}, 64'd0);
  endtask

  initial begin
    int mode;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_m_hi = '0; req_m_lo = '0; req_m_odd = 1'b0; req_k = '0;
    req_c_hi = '0; req_c_lo = '0; req_c_odd = 1'b0;
    mgmt_waitrequest = 1'b0;
    pll_locked = 1'b0;
    repeat (2) @(posedge refclk);
    @(negedge refclk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // plan sequence with no stalls and steady lock
    set_plan_req();
    fill(1'b0, 1'b1);
    run_txn();
    check_eq("plan_done_at_24", 64'(got_done), 64'd24);

    // M write stalled 5 cycles
    fill(1'b0, 1'b1);
    for (int i = 2; i <= 6; i++) wreq_arr[i] = 1'b1;
    run_txn();
    check_eq("stall_done_at_29", 64'(got_done), 64'd29);

    // lock glitch: 1 x10, 0 x1, then 1
    fill(1'b0, 1'b1);
    lock_arr[18] = 1'b0;
    run_txn();
    check_eq("glitch_done_at_35", 64'(got_done), 64'd35);

    // lock never arrives
    fill(1'b0, 1'b0);
    run_txn();
    check_eq("timeout_at_100", 64'(got_to), 64'd100);

    // reset during WR_K, then a fresh request
    set_plan_req();
    @(posedge refclk); #1;
    req_m_hi = t_m_hi; req_m_lo = t_m_lo; req_m_odd = t_m_odd; req_k = t_k;
    req_c_hi = t_c_hi; req_c_lo = t_c_lo; req_c_odd = t_c_odd;
    req_valid = 1'b1;
    mgmt_waitrequest = 1'b0;
    pll_locked = 1'b1;
    @(posedge refclk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge refclk);
    #1;
    check_eq("pre_rst_addr", {57'b0, mgmt_write, mgmt_address}, {57'b0, 1'b1, 6'h07});
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    @(posedge refclk); #1;
    check_eq("midrst_write_held", {63'b0, mgmt_write}, 64'd0);
    @(negedge refclk);
    rst_n = 1'b1;
    fill(1'b0, 1'b1);
    run_txn();

    // randomized requests, stalls and lock behaviour
    for (int n = 0; n < 20; n++) begin
      t_m_hi = 8'($urandom_range(0, 255)); t_m_lo = 8'($urandom_range(0, 255));
      t_m_odd = 1'($urandom_range(0, 1));  t_k = $urandom;
      t_c_hi = 8'($urandom_range(0, 255)); t_c_lo = 8'($urandom_range(0, 255));
      t_c_odd = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 2);
      for (int i = 0; i < WIN; i++) begin
        wreq_arr[i] = ($urandom_range(0, 3) == 0);
        case (mode)
          0:       lock_arr[i] = 1'b1;
          1:       lock_arr[i] = ($urandom_range(0, 15) != 0);
          default: lock_arr[i] = ($urandom_range(0, 7) != 0);
        endcase
      end
      run_txn();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
